// File: rtl/fp_op_sequencer_if.sv
// Avalon-MM slave register bus for fp_op_sequencer.
interface fp_op_sequencer_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/fp_op_sequencer.sv
// Register-mapped sequencer issuing one operation to an FP core and capturing its result.
// Optional macro FP_SEQ_IRQ_EN enables the irq_en control bit and the level interrupt.
module fp_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  fp_op_sequencer_if.slave       bus,
  output logic [31:0]            fp_dataa,
  output logic [31:0]            fp_datab,
  output logic [1:0]             fp_op,
  output logic                   fp_start,
  input  logic                   fp_done,
  input  logic [31:0]            fp_result,
  output logic                   irq
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [31:0]        opa;
  logic [31:0]        opb;
  logic [31:0]        result;
  logic [1:0]         op;
  logic               done;
  logic               timeout;
  logic               overrun;
  logic               irq_en;
  logic               busy;

  logic wr_opa, wr_opb, wr_ctrl, go, rd_status, rd_result;

  assign busy      = (state != IDLE);
  assign wr_opa    = bus.write && (bus.address == ADDR_W'(0));
  assign wr_opb    = bus.write && (bus.address == ADDR_W'(1));
  assign wr_ctrl   = bus.write && (bus.address == ADDR_W'(2));
  assign go        = wr_ctrl && bus.writedata[2];
  assign rd_status = bus.read && (bus.address == ADDR_W'(3));
  assign rd_result = bus.read && (bus.address == ADDR_W'(4));

  assign fp_dataa = opa;
  assign fp_datab = opb;
  assign fp_op    = op;

  // Sequencing FSM; CAPTURE's done set is placed after the RESULT-read clear so the set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      fp_start <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      result   <= '0;
      op       <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      fp_start <= 1'b0;

      if (go && busy)
        overrun <= 1'b1;
      else if (rd_status)
        overrun <= 1'b0;

      if (rd_result)
        done <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_opa)  opa <= bus.writedata;
          if (wr_opb)  opb <= bus.writedata;
          if (wr_ctrl) op  <= bus.writedata[1:0];
          if (go) begin
            state    <= ISSUE;
            fp_start <= 1'b1;
            done     <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        ISSUE: begin
          counter <= CNT_W'(TIMEOUT_CYCLES);
          state   <= WAIT;
        end
        WAIT: begin
          // A completion in the final counted cycle still counts as success.
          if (fp_done) begin
            result <= fp_result;
            state  <= CAPTURE;
          end else begin
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
              timeout <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        CAPTURE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_SEQ_IRQ_EN
  // irq_en stays writable while busy; only the operation fields are locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= bus.writedata[3];
      irq <= irq_en & (done | timeout);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Registered read mux; go is never stored so it cannot read back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        ADDR_W'(0): bus.readdata <= opa;
        ADDR_W'(1): bus.readdata <= opb;
        ADDR_W'(2): bus.readdata <= {28'd0, irq_en, 1'b0, op};
        ADDR_W'(3): bus.readdata <= {27'd0, irq_en, overrun, timeout, done, busy};
        ADDR_W'(4): bus.readdata <= result;
        default:    bus.readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: directed scenarios plus randomized operations
// checked against a transaction-level model of the register map.
module tb_fp_op_sequencer;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fp_dataa, fp_datab, fp_result;
  logic [1:0]  fp_op;
  logic        fp_start, fp_done, irq;

  fp_op_sequencer_if #(.ADDR_W(3)) bus ();

  fp_op_sequencer #(.TIMEOUT_CYCLES(T), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fp_dataa  (fp_dataa),
    .fp_datab  (fp_datab),
    .fp_op     (fp_op),
    .fp_start  (fp_start),
    .fp_done   (fp_done),
    .fp_result (fp_result),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_start = 0;

  always @(negedge clk) if (fp_start) n_start++;

  // Transaction-level model state
  logic [31:0] m_opa, m_opb, m_result;
  logic [1:0]  m_op;
  bit          m_done, m_timeout, m_overrun, m_irq_en;

  function automatic bit irq_en_eff();
`ifdef FP_SEQ_IRQ_EN
    return m_irq_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_status();
    return {27'd0, irq_en_eff(), m_overrun, m_timeout, m_done, 1'b0};
  endfunction

  function automatic logic exp_irq();
    return irq_en_eff() & (m_done | m_timeout);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.write = 1'b1; bus.writedata = d;
    step(1);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a; bus.read = 1'b1;
    step(1);
    bus.read = 1'b0;
    d = bus.readdata;
    if (a == 3'd3) m_overrun = 1'b0;
    if (a == 3'd4) m_done    = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a);
    logic [31:0] exp, d;
    case (a)
      3'd0:    exp = m_opa;
      3'd1:    exp = m_opb;
      3'd3:    exp = exp_status();
      3'd4:    exp = m_result;
      default: exp = '0;
    endcase
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic model_reset();
    m_opa = '0; m_opb = '0; m_result = '0; m_op = '0;
    m_done = 0; m_timeout = 0; m_overrun = 0; m_irq_en = 0;
  endtask

  // lat = WAIT cycle in which the core pulses fp_done (0 = never)
  task automatic do_op(input logic [1:0] op, input bit irqen, input int lat,
                       input logic [31:0] res, input bit interfere);
    int s0;
    s0 = n_start;
    bus_write(3'd2, {28'd0, irqen, 1'b1, op});
    m_op = op; m_irq_en = irqen; m_done = 0; m_timeout = 0;
    check("issue_start", 32'(fp_start), 32'd1);
    check("issue_dataa", fp_dataa, m_opa);
    check("issue_datab", fp_datab, m_opb);
    check("issue_op",    32'(fp_op), 32'(m_op));
    step(1);
    check("start_width", 32'(fp_start), 32'd0);
    for (int c = 1; c <= int'(T) + 2; c++) begin
      fp_done   = (c == lat);
      fp_result = (c == lat) ? res : $urandom;
      if (interfere && c == 1) begin
        bus.address = 3'd0; bus.write = 1'b1; bus.writedata = $urandom;
      end else if (interfere && c == 2) begin
        bus.address = 3'd2; bus.write = 1'b1; bus.writedata = {28'd0, irqen, 1'b1, ~op};
      end else begin
        bus.write = 1'b0;
      end
      step(1);
    end
    fp_done = 1'b0; bus.write = 1'b0;
    if (interfere) m_overrun = 1'b1;
    if (lat != 0 && lat <= int'(T)) begin
      m_result = res; m_done = 1'b1;
    end else begin
      m_timeout = 1'b1;
    end
    check("start_pulses", 32'(n_start - s0), 32'd1);
    check("op_hold",    32'(fp_op), 32'(m_op));
    check("dataa_hold", fp_dataa, m_opa);
    check("irq_level",  32'(irq), 32'(exp_irq()));
    check_reg("status", 3'd3);
    if (interfere) check_reg("status_reread", 3'd3);
    check_reg("result", 4'd4);
    step(1);
    check("irq_after_read", 32'(irq), 32'(exp_irq()));
    check_reg("status_after_read", 3'd3);
  endtask

  initial begin
    logic [31:0] d;
    int s0;
    reset = 1'b1;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    fp_done = 1'b0; fp_result = '0;
    model_reset();
    step(2);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_fp_start", 32'(fp_start), 32'd0);
    check("rst_irq",      32'(irq), 32'd0);
    check("rst_dataa",    fp_dataa, 32'd0);
    reset = 1'b0;
    step(1);
    check_reg("rst_status", 3'd3);
    check_reg("rst_result", 3'd4);
    bus.address = 3'd5;
    step(1);
    check("unmapped_reads_zero", bus.readdata, 32'd0);

    // Multiply 1.0 * 2.0, core answers in WAIT cycle 5
    bus_write(3'd0, 32'h3F80_0000); m_opa = 32'h3F80_0000;
    bus_write(3'd1, 32'h4000_0000); m_opb = 32'h4000_0000;
    check_reg("opa_readback", 3'd0);
    do_op(2'd2, 1'b0, 5, 32'h4000_0000, 1'b0);

    // Core never answers: timeout, RESULT retained
    do_op(2'd0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);

    // Second go and OPA write while busy
    do_op(2'd1, 1'b0, 5, 32'h1234_5678, 1'b1);
    check_reg("opa_locked", 3'd0);

    // Completion coincides with counter expiry
    do_op(2'd3, 1'b0, int'(T), 32'hCAFE_F00D, 1'b0);

    // Interrupt enable path
    do_op(2'd0, 1'b1, 3, 32'h0BAD_F00D, 1'b0);

    // Reset during WAIT, late fp_done after release
    s0 = n_start;
    bus_write(3'd2, 32'h0000_0007);
    step(3);
    reset = 1'b1;
    #2;
    check("midop_rst_start", 32'(fp_start), 32'd0);
    check("midop_rst_rdata", bus.readdata, 32'd0);
    step(1);
    reset = 1'b0;
    model_reset();
    step(1);
    fp_done = 1'b1; fp_result = 32'h5555_AAAA;
    step(1);
    fp_done = 1'b0;
    step(2);
    check_reg("midop_status", 3'd3);
    check_reg("midop_result", 3'd4);
    check("midop_irq", 32'(irq), 32'd0);
    check("midop_starts", 32'(n_start - s0), 32'd1);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; bus_write(3'd0, d); m_opa = d;
      end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; bus_write(3'd1, d); m_opb = d;
      end
      do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, T + 2)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) check_reg("rand_opb", 3'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_op_sequencer.md
FP_OP_SEQUENCER -- requirements
Module: fp_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles waited for fp_done before abort (range 2..65535).
REQ-002 SHALL have parameter ADDR_W, default 3, meaning Avalon slave address width.
REQ-003 SHALL have clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have address  in  ADDR_W  register select: 0 OPA, 1 OPB, 2 CTRL, 3 STATUS, 4 RESULT; others read 0.
REQ-006 SHALL have read  in  1  read strobe, used only for read side effects.
REQ-007 SHALL have write  in  1  write strobe.
REQ-008 SHALL have writedata  in  32  write data.
REQ-009 SHALL have readdata  out  32  registered read data.
REQ-010 SHALL have fp_dataa / fp_datab  out  32 each  operands to FP core, driven from OPA/OPB.
REQ-011 SHALL have fp_op  out  2  operation code: 0 add, 1 sub, 2 mul, 3 div.
REQ-012 SHALL have fp_start  out  1  one-cycle start pulse to FP core.
REQ-013 SHALL have fp_done  in  1  FP core completion pulse.
REQ-014 SHALL have fp_result  in  32  FP core result, valid when fp_done=1.
REQ-015 SHALL have irq  out  1  level interrupt.

Function
REQ-016 readdata SHALL update every cycle to the selected register value, one-cycle latency after address.
REQ-017 Writes to OPA, OPB, CTRL.op SHALL be ignored while busy.
REQ-018 CTRL write: bits[1:0] op, bit2 go, bit3 irq_en; go is self-clearing and never reads back.
REQ-019 STATUS read: bit0 busy, bit1 done, bit2 timeout, bit3 overrun, bit4 irq_en.
REQ-020 FSM states: IDLE, ISSUE, WAIT, CAPTURE.
REQ-021 IDLE->ISSUE on CTRL write with go=1; clears done and timeout.
REQ-022 ISSUE: fp_start=1 exactly one cycle, counter loaded with TIMEOUT_CYCLES; ->WAIT.
REQ-023 WAIT: fp_done=1 -> CAPTURE, RESULT<=fp_result; else decrement counter, counter reaching 0 -> IDLE with timeout=1, RESULT unchanged.
REQ-024 fp_done and counter expiry in same cycle: done SHALL win.
REQ-025 CAPTURE: done<=1 -> IDLE; fp_done in IDLE/ISSUE/CAPTURE SHALL be ignored.
REQ-026 busy SHALL be 1 in ISSUE, WAIT, CAPTURE.
REQ-027 go while busy SHALL be ignored and set overrun; overrun cleared by STATUS read.
REQ-028 read=1 with address=4 SHALL clear done the following cycle; readdata still returns RESULT.
REQ-029 done set and RESULT read in same cycle: set SHALL win.
REQ-030 Operation start to done visible in STATUS: 3 cycles plus FP core latency.

Reset
REQ-031 Reset SHALL force FSM to IDLE, fp_start=0, counter=0, irq=0, readdata=0.
REQ-032 Reset SHALL clear OPA, OPB, RESULT, op, irq_en, done, timeout, overrun.
REQ-033 Reset asserted mid-operation SHALL abort immediately; late fp_done after release is ignored.

Configuration
REQ-034 Macro FP_SEQ_IRQ_EN defined: irq = irq_en & (done | timeout).
REQ-035 Macro FP_SEQ_IRQ_EN undefined: irq tied 0, irq_en bit writes ignored, STATUS bit4 reads 0.

Verification
REQ-036 OPA=0x3F800000, OPB=0x40000000, CTRL=0x6 (mul, go); core returns 0x40000000 after 5 cycles -> one fp_start pulse, STATUS=0x02, RESULT=0x40000000.
REQ-037 Core never asserts fp_done, TIMEOUT_CYCLES=8 -> IDLE after 8 WAIT cycles, STATUS=0x04, RESULT unchanged.
REQ-038 Second go plus OPA write during WAIT -> OPA unchanged, no second fp_start, STATUS bit3=1; STATUS read then reads bit3=0.
REQ-039 fp_done coincident with final counter cycle -> STATUS=0x02, timeout=0.
REQ-040 Reset pulse during WAIT, fp_done 2 cycles after release -> STATUS=0x00, RESULT=0.
REQ-041 FP_SEQ_IRQ_EN defined, CTRL=0xC (irq_en, go) -> irq rises with done, falls after RESULT read.
